// File: rtl/calc_sequencer_if.sv
// ALU handshake bundle between the entry sequencer (master) and the ALU (slave).
interface calc_sequencer_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0]   alu_a;
   logic [WIDTH-1:0]   alu_b;
   logic [1:0]         alu_op;
   logic               alu_start;
   logic               alu_done;
   logic               alu_err;
   logic [2*WIDTH-1:0] alu_result;

   modport master (
      output alu_a, alu_b, alu_op, alu_start,
      input  alu_done, alu_err, alu_result
   );

   modport slave (
      input  alu_a, alu_b, alu_op, alu_start,
      output alu_done, alu_err, alu_result
   );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator entry sequencer: operand A, operator, operand B, ALU run, then
// result/error display with optional chaining of the result into operand A.
module calc_sequencer #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena_i,
   input  logic [WIDTH-1:0]   key_val_i,
   input  logic               key_enter_i,
   input  logic               key_clear_i,
   calc_sequencer_if.master   alu,
   output logic [2*WIDTH-1:0] disp_value_o,
   output logic               disp_err_o,
   output logic               busy_o,
   output logic [2:0]         state_o
);
   localparam int unsigned RW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ent_sync_q, clr_sync_q;
   logic             ent_last_q;
   logic             enter_evt, clear_lvl;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [RW-1:0]    res_q, res_d, disp_q, disp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             start_q, start_d, busy_q, busy_d, err_q, err_d;

   // Button synchronizers run regardless of ena so edges seen while frozen are consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_sync_q <= '0;
         ent_last_q <= 1'b0;
         clr_sync_q <= '0;
      end else begin
         ent_sync_q <= {ent_sync_q[0], key_enter_i};
         ent_last_q <= ent_sync_q[1];
         clr_sync_q <= {clr_sync_q[0], key_clear_i};
      end
   end

   assign enter_evt = ent_sync_q[1] & ~ent_last_q;
   assign clear_lvl = clr_sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_A;
      else        state_q <= state_d;
   end

   // Next state: clear wins over everything, enter is ignored while waiting on the ALU.
   always_comb begin
      state_d = state_q;
      if (ena_i) begin
         if (clear_lvl) begin
            state_d = S_A;
         end else begin
            case (state_q)
               S_A:    if (enter_evt) state_d = S_OP;
               S_OP:   if (enter_evt) state_d = S_B;
               S_B:    if (enter_evt) state_d = S_EXEC;
               S_EXEC: begin
                  if (alu.alu_done)                     state_d = alu.alu_err ? S_ERR : S_SHOW;
                  else if (cnt_q == CW'(TIMEOUT - 1)) state_d = S_ERR;
               end
               S_SHOW: if (enter_evt) state_d = (res_q[RW-1:WIDTH] == '0) ? S_OP : S_ERR;
               S_ERR:  if (enter_evt) state_d = S_A;
               default: state_d = S_A;
            endcase
         end
      end
   end

   // Datapath and registered-output next values.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      start_d = ena_i && (state_q == S_B) && (state_d == S_EXEC);
      busy_d  = (state_d == S_EXEC);
      err_d   = (state_d == S_ERR);
      if (ena_i) begin
         if (clear_lvl) begin
            a_d   = '0;
            b_d   = '0;
            op_d  = '0;
            res_d = '0;
            cnt_d = '0;
         end else begin
            case (state_q)
               S_A:  if (enter_evt) a_d  = key_val_i;
               S_OP: if (enter_evt) op_d = key_val_i[1:0];
               S_B:  if (enter_evt) begin
                  b_d   = key_val_i;
                  cnt_d = '0;
               end
               S_EXEC: begin
                  cnt_d = cnt_q + CW'(1);
                  if (alu.alu_done && !alu.alu_err) res_d = alu.alu_result;
               end
               S_SHOW: if (enter_evt && res_q[RW-1:WIDTH] == '0) a_d = res_q[WIDTH-1:0];
               S_ERR: if (enter_evt) begin
                  a_d   = '0;
                  b_d   = '0;
                  op_d  = '0;
                  res_d = '0;
                  cnt_d = '0;
               end
               default: ;
            endcase
         end
         case (state_d)
            S_A, S_OP, S_B: disp_d = RW'(key_val_i);
            S_EXEC:         disp_d = disp_q;
            S_SHOW:         disp_d = res_d;
            default:        disp_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign alu.alu_a     = a_q;
   assign alu.alu_b     = b_q;
   assign alu.alu_op    = op_q;
   assign alu.alu_start = start_q;
   assign disp_value_o  = disp_q;
   assign disp_err_o    = err_q;
   assign busy_o        = busy_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: vector table, directed corner cases,
// and a randomized run against a transaction-level model.
module tb_calc_sequencer;
   localparam int unsigned W  = 4;
   localparam int unsigned TO = 16;

   logic       clk, rst_n, ena, key_enter, key_clear;
   logic [3:0] key_val;
   logic [7:0] disp_value;
   logic       disp_err, busy;
   logic [2:0] state;

   calc_sequencer_if #(.WIDTH(W)) alu_if ();

   calc_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ena_i(ena), .key_val_i(key_val),
      .key_enter_i(key_enter), .key_clear_i(key_clear), .alu(alu_if),
      .disp_value_o(disp_value), .disp_err_o(disp_err), .busy_o(busy), .state_o(state)
   );

   typedef struct {
      logic [3:0] a;
      logic [1:0] op;
      logic [3:0] b;
      int         dly;
      logic [2:0] st;
      logic [7:0] disp;
      logic       err;
   } vec_t;

   int n_chk = 0, n_err = 0, start_cnt = 0;
   int alu_delay = 0;
   bit alu_never = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   always @(negedge clk) if (alu_if.alu_start === 1'b1) start_cnt++;

   // Stub ALU: {err, result}; add, sub (mod 256), mul, div with div-by-zero error.
   function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [1:0] op,
                                         input logic [3:0] b);
      logic [7:0] x, y;
      x = 8'(a);
      y = 8'(b);
      case (op)
         2'd0: return {1'b0, 8'(x + y)};
         2'd1: return {1'b0, 8'(x - y)};
         2'd2: return {1'b0, 8'(x * y)};
         default: return (b == 4'd0) ? 9'h100 : {1'b0, 8'(x / y)};
      endcase
   endfunction

   initial begin
      logic [8:0] r;
      alu_if.alu_done   = 0;
      alu_if.alu_err    = 0;
      alu_if.alu_result = '0;
      forever begin
         @(posedge clk); #1;
         alu_if.alu_done = 0;
         alu_if.alu_err  = 0;
         if (alu_if.alu_start === 1'b1) begin
            r = alu_fn(alu_if.alu_a, alu_if.alu_op, alu_if.alu_b);
            for (int k = 0; k < alu_delay; k++) begin @(posedge clk); #1; end
            if (!alu_never) begin
               alu_if.alu_done   = 1;
               alu_if.alu_err    = r[8];
               alu_if.alu_result = r[7:0];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic press(input logic [3:0] v);
      key_val   = v;
      key_enter = 1;
      repeat (3) tick();
      key_enter = 0;
      repeat (3) tick();
   endtask

   task automatic do_clear();
      key_clear = 1;
      repeat (3) tick();
      key_clear = 0;
      repeat (3) tick();
   endtask

   task automatic exec_entry(input logic [3:0] v);
      key_val   = v;
      key_enter = 1;
      repeat (3) tick();
      key_enter = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 60) begin tick(); n++; end
      chk("exec_bound_busy", 32'(busy), 0);
   endtask

   task automatic run_txn(input logic [3:0] a, input logic [1:0] op, input logic [3:0] b,
                          input int dly);
      press(a);
      press({2'b10, op});
      alu_delay = dly;
      alu_never = 0;
      press(b);
      wait_idle();
   endtask

   vec_t tbl[9];
   int   s0;
   logic [3:0] v, m_a, m_b;
   logic [1:0] m_op;
   logic [7:0] m_res;
   logic [8:0] r;
   int   m_st, d;

   initial begin
      rst_n = 0; ena = 1; key_enter = 0; key_clear = 0; key_val = '0;
      tbl[0] = '{4'd3,  2'd0, 4'd5,  4,  3'd4, 8'd8,   1'b0};
      tbl[1] = '{4'd7,  2'd2, 4'd9,  1,  3'd4, 8'h3F,  1'b0};
      tbl[2] = '{4'd15, 2'd2, 4'd15, 0,  3'd4, 8'hE1,  1'b0};
      tbl[3] = '{4'd9,  2'd1, 4'd4,  2,  3'd4, 8'd5,   1'b0};
      tbl[4] = '{4'd2,  2'd1, 4'd5,  0,  3'd4, 8'hFD,  1'b0};
      tbl[5] = '{4'd3,  2'd3, 4'd0,  1,  3'd5, 8'd0,   1'b1};
      tbl[6] = '{4'd14, 2'd3, 4'd3,  5,  3'd4, 8'd4,   1'b0};
      tbl[7] = '{4'd1,  2'd0, 4'd1,  15, 3'd4, 8'd2,   1'b0};
      tbl[8] = '{4'd1,  2'd0, 4'd1,  16, 3'd5, 8'd0,   1'b1};

      repeat (3) @(posedge clk); #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_disp", 32'(disp_value), 0);
      chk("rst_start", 32'(alu_if.alu_start), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1;
      tick();

      key_val = 4'hA; tick(); tick();
      chk("live_disp_A", 32'(disp_value), 32'h0A);

      // Vector table.
      foreach (tbl[i]) begin
         s0 = start_cnt;
         run_txn(tbl[i].a, tbl[i].op, tbl[i].b, tbl[i].dly);
         chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("tbl%0d_disp", i), 32'(disp_value), 32'(tbl[i].disp));
         chk($sformatf("tbl%0d_err", i), 32'(disp_err), 32'(tbl[i].err));
         chk($sformatf("tbl%0d_a", i), 32'(alu_if.alu_a), 32'(tbl[i].a));
         chk($sformatf("tbl%0d_op", i), 32'(alu_if.alu_op), 32'(tbl[i].op));
         chk($sformatf("tbl%0d_b", i), 32'(alu_if.alu_b), 32'(tbl[i].b));
         chk($sformatf("tbl%0d_starts", i), 32'(start_cnt - s0), 1);
         if (tbl[i].st == 3'd4) do_clear();
         else press(4'd0);
         chk($sformatf("tbl%0d_back_A", i), 32'(state), 0);
         chk($sformatf("tbl%0d_a_zero", i), 32'(alu_if.alu_a), 0);
      end

      // Timeout: done never comes, ERR exactly on the 16th edge after EXEC entry.
      press(4'd1); press(4'd0);
      alu_never = 1; s0 = start_cnt;
      exec_entry(4'd1);
      chk("to_entry_state", 32'(state), 3);
      chk("to_start_hi", 32'(alu_if.alu_start), 1);
      tick();
      chk("to_start_lo", 32'(alu_if.alu_start), 0);
      chk("to_busy", 32'(busy), 1);
      repeat (14) tick();
      chk("to_edge15_exec", 32'(state), 3);
      tick();
      chk("to_edge16_err", 32'(state), 5);
      chk("to_disp_err", 32'(disp_err), 1);
      chk("to_busy_lo", 32'(busy), 0);
      chk("to_one_start", 32'(start_cnt - s0), 1);
      press(4'd0);
      chk("err_exit_state", 32'(state), 0);
      chk("err_exit_flag", 32'(disp_err), 0);
      alu_never = 0;

      // Done on edge 16 wins over the timeout.
      press(4'd1); press(4'd0);
      alu_delay = 15;
      exec_entry(4'd2);
      repeat (15) tick();
      chk("to15_still_exec", 32'(state), 3);
      tick();
      chk("to16_show", 32'(state), 4);
      chk("to16_disp", 32'(disp_value), 3);
      do_clear();

      // Chaining: 8 goes into A, 0x12 cannot chain.
      run_txn(4'd3, 2'd0, 4'd5, 2);
      press(4'hF);
      chk("chain_state", 32'(state), 1);
      chk("chain_a", 32'(alu_if.alu_a), 8);
      press(4'd0);
      alu_delay = 1;
      press(4'd10);
      wait_idle();
      chk("chain_disp", 32'(disp_value), 32'h12);
      press(4'd0);
      chk("chain_ovf_state", 32'(state), 5);
      chk("chain_ovf_disp", 32'(disp_value), 0);
      press(4'd0);

      // Clear and enter together in B.
      press(4'd6); press(4'd2);
      s0 = start_cnt;
      key_val = 4'd7; key_enter = 1; key_clear = 1;
      repeat (3) tick();
      chk("prio_state", 32'(state), 0);
      chk("prio_a", 32'(alu_if.alu_a), 0);
      chk("prio_op", 32'(alu_if.alu_op), 0);
      key_enter = 0; key_clear = 0;
      repeat (4) tick();
      chk("prio_state_after", 32'(state), 0);
      chk("prio_no_start", 32'(start_cnt - s0), 0);

      // Enter while disabled is dropped.
      ena = 0;
      press(4'd9);
      ena = 1;
      repeat (3) tick();
      chk("ena_drop_state", 32'(state), 0);
      chk("ena_drop_a", 32'(alu_if.alu_a), 0);

      // Async reset mid-EXEC; the ALU's late done must be ignored.
      press(4'd4); press(4'd0);
      alu_delay = 6;
      exec_entry(4'd2);
      chk("rx_exec", 32'(state), 3);
      tick();
      #2 rst_n = 0;
      #1;
      chk("rx_state", 32'(state), 0);
      chk("rx_busy", 32'(busy), 0);
      chk("rx_a", 32'(alu_if.alu_a), 0);
      chk("rx_b", 32'(alu_if.alu_b), 0);
      chk("rx_disp", 32'(disp_value), 0);
      #1 rst_n = 1;
      repeat (10) tick();
      chk("rx_late_done", 32'(state), 0);

      // Randomized run against a transaction-level model.
      m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0;
      for (int it = 0; it < 60; it++) begin
         v = 4'($urandom_range(0, 15));
         case (m_st)
            0: begin
               press(v); m_a = v; m_st = 1;
               chk("rnd_A_state", 32'(state), 1);
               chk("rnd_A_a", 32'(alu_if.alu_a), 32'(m_a));
            end
            1: begin
               press(v); m_op = v[1:0]; m_st = 2;
               chk("rnd_OP_state", 32'(state), 2);
               chk("rnd_OP_op", 32'(alu_if.alu_op), 32'(m_op));
               chk("rnd_OP_disp", 32'(disp_value), 32'(v));
            end
            2: begin
               d = int'($urandom_range(0, 18));
               alu_delay = d; alu_never = 0; s0 = start_cnt;
               press(v); m_b = v;
               wait_idle();
               r = alu_fn(m_a, m_op, m_b);
               if (d >= int'(TO) || r[8]) m_st = 5;
               else begin m_st = 4; m_res = r[7:0]; end
               chk("rnd_EX_state", 32'(state), 32'(m_st));
               chk("rnd_EX_disp", 32'(disp_value), (m_st == 4) ? 32'(m_res) : 0);
               chk("rnd_EX_err", 32'(disp_err), (m_st == 5) ? 1 : 0);
               chk("rnd_EX_b", 32'(alu_if.alu_b), 32'(m_b));
               chk("rnd_EX_starts", 32'(start_cnt - s0), 1);
            end
            4: begin
               if ($urandom_range(0, 3) == 0) begin
                  do_clear(); m_st = 0; m_a = 0; m_b = 0; m_op = 0;
               end else begin
                  press(v);
                  if (m_res[7:4] == 4'd0) begin m_a = m_res[3:0]; m_st = 1; end
                  else m_st = 5;
               end
               chk("rnd_SH_state", 32'(state), 32'(m_st));
               chk("rnd_SH_a", 32'(alu_if.alu_a), 32'(m_a));
            end
            default: begin
               press(v); m_st = 0; m_a = 0; m_b = 0; m_op = 0;
               chk("rnd_ER_state", 32'(state), 0);
               chk("rnd_ER_a", 32'(alu_if.alu_a), 0);
               chk("rnd_ER_b", 32'(alu_if.alu_b), 0);
               chk("rnd_ER_op", 32'(alu_if.alu_op), 0);
               chk("rnd_ER_flag", 32'(disp_err), 0);
            end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
